// File: rtl/crypt_pkg.sv
// Shared types and constants for the decryption-core sequencer.
package crypt_pkg;

  typedef enum logic [2:0] {IDLE, CFG, ALIGN, RUN, DRAIN} state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam int SHIFT_MOD  = 26;
  localparam int KEY_PHASES = 3;

  typedef struct packed {
    logic is_real;
    logic last;
  } tag_t;

  function automatic logic [1:0] sanitize_dir(input logic [1:0] raw);
    logic [1:0] d;
    case (raw)
      DIR_RIGHT: d = DIR_RIGHT;
      DIR_LEFT:  d = DIR_LEFT;
      default:   d = DIR_NONE;
    endcase
    return d;
  endfunction

  // Raw shift is at most 31, so a single conditional subtract folds it into 0..25.
  function automatic logic [4:0] fold_shift(input logic [4:0] raw);
    return (raw >= 5'(SHIFT_MOD)) ? raw - 5'(SHIFT_MOD) : raw;
  endfunction

endpackage

// File: rtl/crypt_out_fifo.sv
// First-word fall-through output FIFO; head entry is presented combinationally.
module crypt_out_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q < CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign valid_o = (cnt_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/crypt_stream_ctrl.sv
// Sequencer feeding the stall-able byte decryption core, with output FIFO.
// Optional statistics counters are compiled in with CRYPT_CTRL_STATS_EN.
module crypt_stream_ctrl #(
  parameter int N           = 8,
  parameter int LAT         = 3,
  parameter int OFIFO_DEPTH = 4,
  parameter int KEY_PHASES  = 3
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [1:0]   cfg_direction,
  input  logic [4:0]   cfg_shift,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  input  logic         s_first,
  input  logic         s_last,
  output logic         core_en,
  output logic [N-1:0] core_din,
  output logic [1:0]   core_direction,
  output logic [4:0]   core_shift_num,
  input  logic [N-1:0] core_dout,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         err_cfg
`ifdef CRYPT_CTRL_STATS_EN
  ,
  output logic [15:0]  stat_bytes,
  output logic [15:0]  stat_frames,
  output logic [15:0]  stat_pads
`endif
);

  import crypt_pkg::*;

  localparam int PH_W = (KEY_PHASES > 1) ? $clog2(KEY_PHASES) : 1;
  localparam int CW   = $clog2(OFIFO_DEPTH) + 1;

  state_e            state_q;
  logic [PH_W-1:0]   phase_q, phase_d;
  tag_t [LAT-1:0]    tag_q;
  tag_t              tag_new;
  logic [1:0]        dir_q;
  logic [4:0]        shift_q;
  logic              err_q;
  logic [CW-1:0]     fifo_cnt;
  logic [N:0]        fifo_rdata;
  logic              fifo_valid;
  logic              space, step, inflight, push, pop;

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < LAT; i++) inflight = inflight | tag_q[i].is_real;
  end

  // Step decision uses the FIFO count before any same-cycle pop.
  always_comb begin
    space    = (fifo_cnt < CW'(OFIFO_DEPTH));
    step     = 1'b0;
    core_din = '0;
    tag_new  = '0;
    s_ready  = 1'b0;
    unique case (state_q)
      ALIGN: step = (phase_q != '0) && space;
      RUN: begin
        s_ready = space;
        if (s_valid && space) begin
          step            = 1'b1;
          core_din        = s_data;
          tag_new.is_real = 1'b1;
          tag_new.last    = s_last;
        end
      end
      DRAIN:   step = inflight && space;
      default: step = 1'b0;
    endcase
    phase_d = (phase_q == PH_W'(KEY_PHASES - 1)) ? '0 : phase_q + 1'b1;
  end

  assign core_en = step;
  assign push    = step && tag_q[LAT-1].is_real;
  assign pop     = fifo_valid && m_ready;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      tag_q   <= '0;
      dir_q   <= DIR_NONE;
      shift_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (s_valid && s_first) state_q <= CFG;
        CFG: begin
          dir_q   <= sanitize_dir(cfg_direction);
          shift_q <= fold_shift(cfg_shift);
          if (cfg_direction == 2'b11) err_q <= 1'b1;
          state_q <= (phase_q != '0) ? ALIGN : RUN;
        end
        ALIGN:   if (phase_q == '0) state_q <= RUN;
        RUN:     if (step && s_last) state_q <= DRAIN;
        DRAIN:   if (!inflight) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // The tag at the tail belongs to the byte the core is emitting this step.
      if (step) begin
        phase_q <= phase_d;
        tag_q   <= {tag_q[LAT-2:0], tag_new};
      end
    end
  end

  crypt_out_fifo #(
    .W     (N + 1),
    .DEPTH (OFIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i ({tag_q[LAT-1].last, core_dout}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign m_valid        = fifo_valid;
  assign m_data         = fifo_rdata[N-1:0];
  assign m_last         = fifo_rdata[N];
  assign core_direction = dir_q;
  assign core_shift_num = shift_q;
  assign err_cfg        = err_q;
  assign busy           = (state_q != IDLE) || (fifo_cnt != '0);

`ifdef CRYPT_CTRL_STATS_EN
  logic [15:0] bytes_q, frames_q, pads_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      bytes_q  <= '0;
      frames_q <= '0;
      pads_q   <= '0;
    end else begin
      if (push && (bytes_q != 16'hFFFF)) bytes_q <= bytes_q + 1'b1;
      if (push && tag_q[LAT-1].last && (frames_q != 16'hFFFF)) frames_q <= frames_q + 1'b1;
      if (step && !tag_new.is_real && (pads_q != 16'hFFFF)) pads_q <= pads_q + 1'b1;
    end
  end

  assign stat_bytes  = bytes_q;
  assign stat_frames = frames_q;
  assign stat_pads   = pads_q;
`endif

endmodule

// File: tb/tb_crypt_stream_ctrl.sv
// Self-checking bench for crypt_stream_ctrl with a behavioural 3-stage XOR core.
module tb_crypt_stream_ctrl;

  localparam int N     = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int KP    = 3;

  logic         clock;
  logic         rst;
  logic [1:0]   cfg_direction;
  logic [4:0]   cfg_shift;
  logic         s_valid, s_ready, s_first, s_last;
  logic [N-1:0] s_data;
  logic         core_en;
  logic [N-1:0] core_din, core_dout;
  logic [1:0]   core_direction;
  logic [4:0]   core_shift_num;
  logic         m_valid, m_ready, m_last;
  logic [N-1:0] m_data;
  logic         busy, err_cfg;

  crypt_stream_ctrl #(.N(N), .LAT(LAT), .OFIFO_DEPTH(DEPTH), .KEY_PHASES(KP)) dut (
    .clock          (clock),
    .rst            (rst),
    .cfg_direction  (cfg_direction),
    .cfg_shift      (cfg_shift),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_first        (s_first),
    .s_last         (s_last),
    .core_en        (core_en),
    .core_din       (core_din),
    .core_direction (core_direction),
    .core_shift_num (core_shift_num),
    .core_dout      (core_dout),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .err_cfg        (err_cfg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert, n_fail;
  int bp_mode;
  bit err_exp;
  int base, pads, dsteps, sent;
  logic [7:0] bq[$];
  logic [8:0] step_log[$];
  logic [8:0] out_q[$];
  logic [8:0] exp_q[$];

  logic [7:0] key [KP] = '{8'h5A, 8'hC3, 8'h96};
  logic [7:0] pipe [LAT];
  int core_ph;

  assign core_dout = pipe[LAT-1];

  always @(negedge clock) begin
    if (bp_mode == 0)      m_ready = 1'b1;
    else if (bp_mode == 1) m_ready = 1'b0;
    else                   m_ready = 1'($urandom_range(0, 1));
  end

  // Core model: each step XORs the incoming byte with the key of the core's own phase.
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      core_ph <= 0;
    end else begin
      if (m_valid && m_ready) out_q.push_back({m_last, m_data});
      if (core_en) begin
        step_log.push_back({s_valid && s_ready, core_din});
        pipe[0] <= core_din ^ key[core_ph];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        core_ph <= (core_ph + 1) % KP;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input logic [1:0] dir,
                            input logic [4:0] shf, input int abort_after, output int nsent);
    int budget;
    int n;
    n = bytes.size();
    nsent = 0;
    for (int k = 0; k < n; k++) begin
      if (k == abort_after) break;
      @(negedge clock);
      s_valid = 1'b1; s_data = bytes[k];
      s_first = (k == 0); s_last = (k == n - 1);
      cfg_direction = dir; cfg_shift = shf;
      #1;
      budget = 0;
      while (!s_ready && budget < 300) begin
        @(negedge clock); #1; budget++;
      end
      if (!s_ready) begin
        chk("s_ready handshake timeout", s_ready, 1);
        break;
      end
      exp_q.push_back({(k == n - 1), bytes[k] ^ key[k % KP]});
      @(posedge clock);
      nsent++;
    end
    @(negedge clock);
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge clock); #1;
    while (busy && b < 500) begin
      @(negedge clock); #1; b++;
    end
    chk("busy drain timeout", busy, 0);
  endtask

  task automatic check_frame(input string tag, input int b0, input int npads, input int n);
    logic [8:0] e;
    bit exp_data;
    int cnt;
    cnt = step_log.size() - b0;
    chk({tag, " step count"}, cnt, npads + n + LAT);
    for (int i = 0; i < cnt; i++) begin
      e = step_log[b0 + i];
      exp_data = (i >= npads) && (i < npads + n);
      chk({tag, " step kind"}, e[8], exp_data);
      if (!exp_data) chk({tag, " pad din"}, e[7:0], 0);
    end
    chk({tag, " out count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk({tag, " out {last,data}"}, out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] bytes[$],
                           input logic [1:0] dir, input logic [4:0] shf);
    int b0, np, ns;
    b0 = step_log.size();
    np = (KP - (b0 % KP)) % KP;
    send_frame(bytes, dir, shf, -1, ns);
    wait_idle();
    check_frame(tag, b0, np, bytes.size());
    if (dir == 2'b11) err_exp = 1'b1;
    chk({tag, " core_direction"}, core_direction, (dir == 2'b11) ? 2'b00 : dir);
    chk({tag, " core_shift_num"}, core_shift_num, 32'(shf) % 26);
    chk({tag, " err_cfg"}, err_cfg, err_exp);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; bp_mode = 2; err_exp = 1'b0;
    rst = 1'b0;
    s_valid = 1'b0; s_data = '0; s_first = 1'b0; s_last = 1'b0;
    cfg_direction = '0; cfg_shift = '0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s_valid = 1'($urandom); s_data = 8'($urandom);
      s_first = 1'($urandom); s_last = 1'($urandom);
      cfg_direction = 2'($urandom); cfg_shift = 5'($urandom);
    end
    #1;
    chk("rst s_ready", s_ready, 0);
    chk("rst core_en", core_en, 0);
    chk("rst core_din", core_din, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst m_last", m_last, 0);
    chk("rst busy", busy, 0);
    chk("rst err_cfg", err_cfg, 0);
    chk("rst core_direction", core_direction, 0);
    chk("rst core_shift_num", core_shift_num, 0);

    // Release; a byte without s_first must be held off
    @(negedge clock);
    s_valid = 1'b1; s_first = 1'b0; s_last = 1'b0;
    bp_mode = 0;
    rst = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    chk("idle s_ready w/o first", s_ready, 0);
    chk("idle busy w/o first", busy, 0);
    chk("idle no steps", step_log.size(), 0);
    s_valid = 1'b0;

    // Basic frame, phase 0
    bq = '{8'h41, 8'h42, 8'h43};
    run_frame("basic", bq, 2'b01, 5'd3);

    // Two-byte frame leaves phase at 2; next frame needs one pad
    bq = '{8'($urandom), 8'($urandom)};
    run_frame("two-byte", bq, 2'b10, 5'd10);
    chk("phase after two-byte", step_log.size() % KP, 2);
    bq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame("aligned", bq, 2'b01, 5'd25);

    // Config sanitising and sticky error
    bq = '{8'($urandom), 8'($urandom)};
    run_frame("cfg illegal", bq, 2'b11, 5'd29);
    bq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame("cfg sticky", bq, 2'b10, 5'd26);

    // Back-pressure: 8 bytes into a 4-entry FIFO with sink stalled
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    base = step_log.size();
    pads = (KP - (base % KP)) % KP;
    fork
      send_frame(bq, 2'b01, 5'd5, -1, sent);
      begin
        bp_mode = 1;
        repeat (16) @(negedge clock);
        #1;
        dsteps = 0;
        for (int i = base; i < step_log.size(); i++) dsteps += int'(step_log[i][8]);
        chk("bp s_ready when full", s_ready, 0);
        chk("bp core_en when full", core_en, 0);
        chk("bp m_valid when full", m_valid, 1);
        chk("bp data steps before stall", dsteps, DEPTH + LAT);
        chk("bp nothing popped", out_q.size(), 0);
        bp_mode = 0;
      end
    join
    wait_idle();
    check_frame("backpressure", base, pads, 8);

    // Random frames under random sink back-pressure
    bp_mode = 2;
    for (int f = 0; f < 5; f++) begin
      bq.delete();
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) bq.push_back(8'($urandom));
      run_frame("random", bq, 2'($urandom_range(0, 3)), 5'($urandom));
    end
    bp_mode = 0;

    // Reset in the middle of a frame
    bq.delete();
    for (int i = 0; i < 5; i++) bq.push_back(8'($urandom));
    send_frame(bq, 2'b01, 5'd4, 2, sent);
    rst = 1'b0;
    #1;
    chk("midrst m_valid", m_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst s_ready", s_ready, 0);
    chk("midrst core_en", core_en, 0);
    chk("midrst err_cfg", err_cfg, 0);
    @(negedge clock);
    out_q.delete(); exp_q.delete(); step_log.delete();
    err_exp = 1'b0;
    rst = 1'b1;
    bq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame("post-reset", bq, 2'b10, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/crypt_stream_ctrl.md
Name: crypt_stream_ctrl

Overview:
- Sequencer that feeds the byte-wise decryption core, a stall-able pipeline advanced only while its enable is high.
- Accepts a framed byte stream with valid/ready and latches the per-frame cipher config.
- Steps the core one byte per enabled cycle, and realigns the core's 3-key XOR phase to key 0 at every frame start.
- Captures the core output into an output FIFO with valid/ready.

Parameters:
- N, 8, byte width of stream and core data.
- LAT, 3, core pipeline depth in enabled steps.
- OFIFO_DEPTH, 4, output FIFO entries, power of two.
- KEY_PHASES, 3, number of XOR key phases in the core.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- cfg_direction  in  2  frame cipher direction: 00 none, 01 right, 10 left, 11 illegal.
- cfg_shift  in  5  frame shift amount, raw.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when high with s_valid.
- s_data  in  N  input byte.
- s_first  in  1  first byte of frame.
- s_last  in  1  last byte of frame.
- core_en  out  1  core step enable.
- core_din  out  N  byte to core.
- core_direction  out  2  latched direction to core.
- core_shift_num  out  5  latched shift, range 0..25.
- core_dout  in  N  core output byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream ready.
- m_data  out  N  output byte.
- m_last  out  1  last output byte of frame.
- busy  out  1  high when state != IDLE or FIFO not empty.
- err_cfg  out  1  sticky; set by an illegal direction.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; phase counter, tag pipe and FIFO are cleared.
  - Every output is 0, including s_ready, core_en, m_valid and err_cfg.
  - core_direction=00 and core_shift_num=0.
- Step: core_en=1 for exactly one cycle per step. Every step increments the phase counter mod KEY_PHASES.
- A step is permitted only while FIFO count < OFIFO_DEPTH. The FIFO is written at most once per step.
- Tags: each step carries a tag {real, last}. The byte issued on step j is pushed into the FIFO from core_dout during step j+LAT (the LAT-th later step), and only if its tag is real. Pad and flush steps are never pushed.
- IDLE:
  - s_ready=0.
  - On s_valid & s_first, go to CFG. The byte is not consumed.
  - s_valid without s_first is held off (s_ready stays 0) and the byte stays pending.
- CFG, one cycle:
  - Latch direction. 11 maps to 00 and sets err_cfg.
  - Latch shift as cfg_shift mod 26, i.e. subtract 26 if cfg_shift >= 26.
  - Go to ALIGN if phase != 0, else RUN.
- ALIGN:
  - Issue (KEY_PHASES - phase) pad steps with core_din=0 and a non-real tag.
  - Go to RUN when phase = 0.
- RUN:
  - s_ready = (FIFO count < OFIFO_DEPTH).
  - On s_valid & s_ready: step with core_din=s_data and tag real; tag last = s_last.
  - s_first seen in RUN is ignored; the byte is treated as data.
  - On an accepted s_last, go to DRAIN.
- DRAIN:
  - s_ready=0.
  - Issue flush steps (core_din=0, non-real tag), subject to the FIFO-space rule, until no real tag remains in flight.
  - Then go to IDLE.
- Phase persists across frames. Only reset clears it.
- core_direction and core_shift_num hold their latched values until the next CFG.
- FIFO:
  - First-word fall-through: m_data, m_last and m_valid are driven from the head entry.
  - A pop happens on m_valid & m_ready.
  - Simultaneous push and pop on a full FIFO is legal only with pop-before-check; the step rule still uses the count before the pop.
- Order preserved; no byte lost or duplicated under any back-pressure pattern.

Optional Feature:
- Macro: CRYPT_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_bytes (16 bits, counts FIFO pushes) and stat_frames (16 bits, counts pushes with last=1).
  - Both saturate at FFFF and clear on reset.
  - Adds stat_pads (16 bits, counts pad and flush steps).
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Decomposition:
- Package crypt_pkg holds:
  - the state enum {IDLE, CFG, ALIGN, RUN, DRAIN};
  - direction constants DIR_NONE=00, DIR_RIGHT=01, DIR_LEFT=10;
  - SHIFT_MOD=26 and KEY_PHASES=3;
  - the tag struct {real, last}.
- Sub-module crypt_out_fifo: synchronous FWFT FIFO, parameters N+1 and OFIFO_DEPTH, with count output.

Test Plan:
- Reset check: rst=0 with random inputs -> all outputs 0, s_ready=0, busy=0. After release, still idle until s_first.
- Basic frame: 3-byte frame 41,42,43, direction=01, cfg_shift=3, m_ready=1, phase 0 -> no pad step; core_shift_num=3; 3 data steps then 3 flush steps; m_data equals core_dout captured at steps 4,5,6; m_last only on the third byte.
- Phase alignment: 2-byte frame from phase 0, so phase=2 at end; next frame -> exactly 1 pad step with core_din=00 before the first data step; pad output not in FIFO.
- Config sanitising: cfg_shift=29 -> core_shift_num=3. cfg_direction=11 -> core_direction=00, err_cfg=1, and it stays 1 through later frames until rst.
- Back-pressure: 8-byte frame with OFIFO_DEPTH=4 and m_ready=0 for 12 cycles -> s_ready and core_en drop once the FIFO is full; after m_ready=1, all 8 bytes arrive in order with a single m_last.
- Reset mid-RUN: assert rst after 2 of 5 bytes -> IDLE next evaluation, FIFO empty, phase 0, m_valid=0; a fresh frame then runs with no pad step.
